stage_view_ctrl: RTL and testbench

STAGE_VIEW_CTRL -- requirements
Module: stage_view_ctrl

---
 rtl/wm_pkg.sv | 20 ++
 rtl/blink_gen.sv | 41 ++++
 rtl/stage_view_ctrl.sv | 110 +++++++++++
 tb/tb_stage_view_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/wm_pkg.sv
// Shared washing-machine definitions: controller state encodings used by
// the controller and by the stage display block.
package wm_pkg;

  typedef enum logic [2:0] {
    ST_SHUTDOWN = 3'd0,
    ST_BEGIN    = 3'd1,
    ST_SET      = 3'd2,
    ST_RUN      = 3'd3,
    ST_ERROR    = 3'd4,
    ST_PAUSE    = 3'd5,
    ST_FINISH   = 3'd6
  } wm_state_t;

  // The unused encoding 7 behaves exactly like shutdown.
  function automatic wm_state_t to_state(input logic [2:0] raw);
    return (raw == 3'd7) ? ST_SHUTDOWN : wm_state_t'(raw);
  endfunction

endpackage

// File: rtl/blink_gen.sv
// Blink timebase: counter 0..DIV-1 with a phase bit that toggles on wrap.
// clr restarts counter and phase from zero.
module blink_gen #(
  parameter int DIV = 25000000
) (
  input  logic cp,
  input  logic rst,
  input  logic clr,
  output logic phase
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;
  logic          ph_q;
  logic          wrap;

  assign wrap = (cnt == CW'(DIV - 1));

  // Count cycles; toggle phase on wrap; restart on clr.
  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      ph_q <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      ph_q <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      ph_q <= ~ph_q;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Phase as it will stand after the coming edge, so a consumer that
  // registers it on that same edge shows each half-period exactly DIV
  // cycles long, starting right at the state change.
  assign phase = clr ? 1'b0 : (ph_q ^ wrap);

endmodule

// File: rtl/stage_view_ctrl.sv
// Stage display controller: totals, highest active stage and stage LEDs
// for the wash controller, all registered with one cycle of latency.
// Optional feature macro: VIEW_BLINK_EN (blink the active stage LED in run).
module stage_view_ctrl
  import wm_pkg::*;
#(
  parameter int NUM_STAGES = 8,
  parameter int TIME_W     = 4,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                                   cp,
  input  logic                                   rst,
  input  logic [2:0]                             state,
  input  logic [NUM_STAGES*TIME_W-1:0]           run_time,
  input  logic [NUM_STAGES*TIME_W-1:0]           set_time,
  input  logic [NUM_STAGES-1:0]                  set_mask,
  output logic [TIME_W+$clog2(NUM_STAGES)-1:0]   show_total,
  output logic [TIME_W-1:0]                      show_current,
  output logic [$clog2(NUM_STAGES)-1:0]          show_index,
  output logic [NUM_STAGES+1:0]                  led_msg
);

  localparam int IDX_W = $clog2(NUM_STAGES);
  localparam int TOT_W = TIME_W + IDX_W;

  wm_state_t                    st;
  wm_state_t                    prev_st;
  logic                         clr;
  logic                         phase;
  logic [NUM_STAGES*TIME_W-1:0] src;
  logic [TOT_W-1:0]             tot_next;
  logic [TIME_W-1:0]            cur_next;
  logic [IDX_W-1:0]             idx_next;
  logic [NUM_STAGES-1:0]        run_nz;
  logic [NUM_STAGES-1:0]        stage_led;
  logic [NUM_STAGES+1:0]        led_next;

  assign st  = to_state(state);
  assign clr = (st != prev_st);
  assign src = (st == ST_SET) ? set_time : run_time;

  blink_gen #(.DIV(BLINK_DIV)) u_blink (
    .cp    (cp),
    .rst   (rst),
    .clr   (clr),
    .phase (phase)
  );

  // Sum all stage times and find the highest-index non-zero stage.
  always_comb begin
    tot_next = '0;
    cur_next = '0;
    idx_next = '0;
    run_nz   = '0;
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      tot_next  = tot_next + TOT_W'(src[k*TIME_W +: TIME_W]);
      run_nz[k] = (run_time[k*TIME_W +: TIME_W] != '0);
      if (src[k*TIME_W +: TIME_W] != '0) begin
        cur_next = src[k*TIME_W +: TIME_W];
        idx_next = IDX_W'(k);
      end
    end
  end

  // Stage LED pattern per state, plus power and set-mode indicators.
  always_comb begin
    stage_led = '0;
    unique case (st)
      ST_SET:            stage_led = set_mask;
      ST_BEGIN,
      ST_PAUSE:          stage_led = run_nz;
      ST_RUN: begin
        stage_led = run_nz;
`ifdef VIEW_BLINK_EN
        stage_led[idx_next] = run_nz[idx_next] & phase;
`endif
      end
      ST_ERROR:          stage_led = {NUM_STAGES{phase}};
      default:           stage_led = '0;
    endcase
    led_next                 = '0;
    led_next[NUM_STAGES-1:0] = stage_led;
    led_next[NUM_STAGES]     = (st == ST_PAUSE) ? phase : (st != ST_SHUTDOWN);
    led_next[NUM_STAGES+1]   = (st == ST_SET);
  end

  // Output registers; numeric outputs freeze while paused.
  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      prev_st      <= ST_SHUTDOWN;
      show_total   <= '0;
      show_current <= '0;
      show_index   <= '0;
      led_msg      <= '0;
    end else begin
      prev_st <= st;
      led_msg <= led_next;
      if (st == ST_SHUTDOWN) begin
        show_total   <= '0;
        show_current <= '0;
        show_index   <= '0;
      end else if (st != ST_PAUSE) begin
        show_total   <= tot_next;
        show_current <= cur_next;
        show_index   <= idx_next;
      end
    end
  end

endmodule

// File: tb/tb_stage_view_ctrl.sv
// Self-checking bench for stage_view_ctrl with a behavioural reference model.
module tb_stage_view_ctrl;

  localparam int NS  = 8;
  localparam int TW  = 4;
  localparam int DIV = 4;

  logic            cp = 1'b0;
  logic            rst = 1'b0;
  logic [2:0]      state;
  logic [NS*TW-1:0] run_time;
  logic [NS*TW-1:0] set_time;
  logic [NS-1:0]   set_mask;
  logic [6:0]      show_total;
  logic [3:0]      show_current;
  logic [2:0]      show_index;
  logic [NS+1:0]   led_msg;

  int n_pass = 0;
  int n_chk  = 0;

  stage_view_ctrl #(.NUM_STAGES(NS), .TIME_W(TW), .BLINK_DIV(DIV)) dut (
    .cp           (cp),
    .rst          (rst),
    .state        (state),
    .run_time     (run_time),
    .set_time     (set_time),
    .set_mask     (set_mask),
    .show_total   (show_total),
    .show_current (show_current),
    .show_index   (show_index),
    .led_msg      (led_msg)
  );

  always #5 cp = ~cp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int               m_prev, m_n, m_s, ph, tot, cur, idx, f;
  bit               found;
  logic [NS-1:0]    nz, stg;
  logic [NS*TW-1:0] src;
  logic [31:0]      e_total, e_cur, e_idx, e_led;

  always @(posedge cp or posedge rst) begin
    if (rst) begin
      m_prev = 0; m_n = 0;
      e_total = 0; e_cur = 0; e_idx = 0; e_led = 0;
    end else begin
      m_s = (state == 3'd7) ? 0 : int'(state);
      if (m_s != m_prev) m_n = 0; else m_n++;
      m_prev = m_s;
      ph = (m_n / DIV) % 2;
      src = (m_s == 2) ? set_time : run_time;
      tot = 0; cur = 0; idx = 0; found = 0;
      for (int k = NS - 1; k >= 0; k--) begin
        f = int'((src >> (k * TW)) & 32'hF);
        tot += f;
        if (!found && f != 0) begin found = 1; cur = f; idx = k; end
        nz[k] = ((run_time >> (k * TW)) & 32'hF) != 0;
      end
      if (m_s == 0) begin
        e_total = 0; e_cur = 0; e_idx = 0;
      end else if (m_s != 5) begin
        e_total = tot; e_cur = cur; e_idx = idx;
      end
      case (m_s)
        1, 5: stg = nz;
        2:    stg = set_mask;
        3: begin
          stg = nz;
`ifdef VIEW_BLINK_EN
          stg[idx] = stg[idx] & (ph != 0);
`endif
        end
        4:       stg = (ph != 0) ? '1 : '0;
        default: stg = '0;
      endcase
      e_led = {22'd0, (m_s == 2), (m_s == 5) ? (ph != 0) : (m_s != 0), stg};
    end
  end

  // Every-cycle comparison against the model.
  always @(posedge cp) begin
    #1;
    if (!rst) begin
      chk("m_total",   32'(show_total),   e_total);
      chk("m_current", 32'(show_current), e_cur);
      chk("m_index",   32'(show_index),   e_idx);
      chk("m_led",     32'(led_msg),      e_led);
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    state = 3'd0; run_time = '0; set_time = '0; set_mask = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst_total", 32'(show_total), 0);
    chk("rst_current", 32'(show_current), 0);
    chk("rst_index", 32'(show_index), 0);
    chk("rst_led", 32'(led_msg), 0);
    repeat (2) @(negedge cp);
    rst = 1'b0;

    // shutdown ignores data
    run_time = 32'h0000_0051;
    @(posedge cp); #1;
    chk("off_total", 32'(show_total), 0);
    chk("off_led", 32'(led_msg), 0);

    // set mode
    @(negedge cp);
    state = 3'd2; set_time = '0; set_time[28 +: 4] = 4'd3; set_time[8 +: 4] = 4'd5;
    set_mask = 8'h84;
    @(posedge cp); #1;
    chk("set_total", 32'(show_total), 8);
    chk("set_current", 32'(show_current), 3);
    chk("set_index", 32'(show_index), 7);
    chk("set_led", 32'(led_msg), 32'h384);

    // begin state
    @(negedge cp); state = 3'd1; run_time = 32'h0000_2001;
    @(posedge cp); #1;
    chk("beg_total", 32'(show_total), 3);
    chk("beg_index", 32'(show_index), 3);
    chk("beg_led", 32'(led_msg), 32'h109);
    @(negedge cp); run_time = '0;
    @(posedge cp); #1;
    chk("zero_current", 32'(show_current), 0);
    chk("zero_index", 32'(show_index), 0);

    // all-max in run
    @(negedge cp); state = 3'd3; run_time = '1;
    @(posedge cp); #1;
    chk("max_total", 32'(show_total), 120);
    chk("max_current", 32'(show_current), 15);
    chk("max_index", 32'(show_index), 7);

    // pause hold
    @(negedge cp); run_time = 32'h0005_0040;
    @(posedge cp); #1;
    chk("pre_pause_total", 32'(show_total), 9);
    @(negedge cp); state = 3'd5;
    for (int i = 0; i < 10; i++) begin
      @(posedge cp); #1;
      chk("pause_total", 32'(show_total), 9);
      chk("pause_power", 32'(led_msg[8]), ((i / 4) % 2));
      if (i == 0) run_time = 32'h0000_0001;
    end

    // error blink, then restart after a state change
    @(negedge cp); state = 3'd4;
    for (int i = 0; i < 6; i++) begin
      @(posedge cp); #1;
      chk("err_leds", 32'(led_msg[7:0]), ((i / 4) % 2) ? 32'hFF : 32'h00);
    end
    @(negedge cp); state = 3'd6;
    @(posedge cp); #1;
    chk("fin_led", 32'(led_msg), 32'h100);
    @(negedge cp); state = 3'd4;
    for (int i = 0; i < 5; i++) begin
      @(posedge cp); #1;
      chk("err_restart", 32'(led_msg[7:0]), (i < 4) ? 32'h00 : 32'hFF);
    end

    // active stage LED in run
    @(negedge cp); state = 3'd3; run_time = '0; run_time[20 +: 4] = 4'd7;
    for (int i = 0; i < 10; i++) begin
      @(posedge cp); #1;
      chk("run_index", 32'(show_index), 5);
`ifdef VIEW_BLINK_EN
      chk("run_led5", 32'(led_msg[5]), ((i / 4) % 2));
`else
      chk("run_led5", 32'(led_msg[5]), 1);
`endif
    end

    // encoding 7 acts as shutdown
    @(negedge cp); state = 3'd7;
    @(posedge cp); #1;
    chk("st7_led", 32'(led_msg), 0);
    chk("st7_total", 32'(show_total), 0);

    // reset mid-run
    @(negedge cp); state = 3'd3; run_time = '0; run_time[8 +: 4] = 4'd6;
    repeat (2) @(posedge cp); #1;
    chk("mid_total", 32'(show_total), 6);
    @(negedge cp); #2 rst = 1'b1;
    #1;
    chk("arst_total", 32'(show_total), 0);
    chk("arst_current", 32'(show_current), 0);
    chk("arst_index", 32'(show_index), 0);
    chk("arst_led", 32'(led_msg), 0);
    @(negedge cp); rst = 1'b0;
    @(posedge cp); #1;
    chk("rel_total", 32'(show_total), 6);
    chk("rel_current", 32'(show_current), 6);
    chk("rel_index", 32'(show_index), 2);
    chk("rel_power", 32'(led_msg[8]), 1);
    repeat (3) @(posedge cp);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
